// File: rtl/tb_dina_map.sv
// -----------------------------------------------------------------------------
// tb_dina_map
//
// Write-side mapper from the RSA output edge onto the tile-buffer port-A write
// bus. One result row (X lanes) per cycle comes in. One registered write word
// (L lanes) goes out, with per-lane enables and a self-incrementing address.
//
// Writeback layouts:
//   C/POS : lane i <= C lane i                       wea 1111
//   C/NEG : lane i <= C lane X-1-i                   wea 1111
//   C/NEW : l_k_0=1 -> lanes 0,1 <= C lanes 0,1      wea 0011
//           l_k_0=0 -> lanes 2,3 <= C lanes 0,1      wea 1100
//   TR    : 2x2 transpose of C lanes 0-1 over two rows, two writes, wea 0011
//
// Ports:
//   clk, sys_rst_n : clock, asynchronous active-low reset
//   TB_dina_sel    : [4:2] mode (000 IDLE, 001 C, 100 TR), [1:0] C direction
//   l_k_0          : NEW half select (1 = lanes 0-1, 0 = lanes 2-3)
//   C_valid        : C_TB_dina holds a valid row this cycle
//   C_TB_dina      : signed result row, lane i at bits [i*RSA_DW +: RSA_DW]
//   addr_load      : load the write address counter with addr_base
//   addr_base      : start address
//   TB_dina        : registered write data, unused lanes are 0
//   TB_wea         : registered per-lane write enables
//   TB_addra       : address of the write presented on the same cycle
//   tr_busy        : the transpose holds a row that is not yet fully written
//
// Lane-fixed layouts (NEW, TR) assume L >= 4 and X >= 2.
// -----------------------------------------------------------------------------
module tb_dina_map #(
    parameter int X              = 4,
    parameter int L              = 4,
    parameter int RSA_DW         = 32,
    parameter int TB_AW          = 10,
    parameter int TB_DINA_SEL_DW = 5
) (
    input  logic                          clk,
    input  logic                          sys_rst_n,
    input  logic [TB_DINA_SEL_DW-1:0]     TB_dina_sel,
    input  logic                          l_k_0,
    input  logic                          C_valid,
    input  logic signed [X*RSA_DW-1:0]    C_TB_dina,
    input  logic                          addr_load,
    input  logic [TB_AW-1:0]              addr_base,
    output logic signed [L*RSA_DW-1:0]    TB_dina,
    output logic [L-1:0]                  TB_wea,
    output logic [TB_AW-1:0]              TB_addra,
    output logic                          tr_busy
);

    localparam logic [2:0] MODE_C  = 3'b001;
    localparam logic [2:0] MODE_TR = 3'b100;

    localparam logic [1:0] DIR_POS = 2'b01;
    localparam logic [1:0] DIR_NEG = 2'b10;
    localparam logic [1:0] DIR_NEW = 2'b11;

    localparam logic [1:0] TR_ROW0 = 2'd0;
    localparam logic [1:0] TR_ROW1 = 2'd1;
    localparam logic [1:0] TR_OUT1 = 2'd2;

    localparam logic [TB_AW-1:0] ADDR_ONE = 1;

    logic [2:0]               mode;
    logic [1:0]               dir;
    logic                     is_c;
    logic                     is_tr;
    logic signed [RSA_DW-1:0] c0;
    logic signed [RSA_DW-1:0] c1;

    assign mode  = TB_dina_sel[4:2];
    assign dir   = TB_dina_sel[1:0];
    assign is_c  = (mode == MODE_C);
    assign is_tr = (mode == MODE_TR);
    assign c0    = C_TB_dina[0 +: RSA_DW];
    assign c1    = C_TB_dina[RSA_DW +: RSA_DW];

    // Transpose buffer: first row (both elements) and the second element of
    // the second row; the second row's first element is written straight out.
    logic [1:0]               tr_state, tr_state_next;
    logic signed [RSA_DW-1:0] r0_lo, r0_hi, r1_hi;
    logic signed [RSA_DW-1:0] r0_lo_next, r0_hi_next, r1_hi_next;

    logic signed [L*RSA_DW-1:0] dina_next;
    logic [L-1:0]               wea_next;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        dina_next     = '0;
        wea_next      = '0;
        tr_state_next = tr_state;
        r0_lo_next    = r0_lo;
        r0_hi_next    = r0_hi;
        r1_hi_next    = r1_hi;

        case (tr_state)
            TR_ROW0: begin
                if (is_tr && C_valid) begin
                    r0_lo_next    = c0;
                    r0_hi_next    = c1;
                    tr_state_next = TR_ROW1;
                end
            end
            TR_ROW1: begin
                if (!is_tr) begin
                    // Mode left with only half a pair: drop it.
                    tr_state_next = TR_ROW0;
                end else if (C_valid) begin
                    dina_next[0 +: RSA_DW]      = r0_lo;
                    dina_next[RSA_DW +: RSA_DW] = c0;
                    wea_next[1:0]               = 2'b11;
                    r1_hi_next                  = c1;
                    tr_state_next               = TR_OUT1;
                end
            end
            TR_OUT1: begin
                // Second half of the pair is always issued, even if the mode
                // changes on this cycle.
                dina_next[0 +: RSA_DW]      = r0_hi;
                dina_next[RSA_DW +: RSA_DW] = r1_hi;
                wea_next[1:0]               = 2'b11;
                tr_state_next               = TR_ROW0;
                if (is_tr && C_valid) begin
                    // Back-to-back pairs: this row is the next pair's first row.
                    r0_lo_next    = c0;
                    r0_hi_next    = c1;
                    tr_state_next = TR_ROW1;
                end
            end
            default: tr_state_next = TR_ROW0;
        endcase

        // The pending transpose write owns the bus on TR_OUT1; a C row that
        // collides with it is not written.
        if (is_c && C_valid && (tr_state != TR_OUT1)) begin
            case (dir)
                DIR_POS: begin
                    for (int i = 0; i < L; i++) begin
                        if (i < X) dina_next[i*RSA_DW +: RSA_DW] = C_TB_dina[i*RSA_DW +: RSA_DW];
                    end
                    wea_next = '1;
                end
                DIR_NEG: begin
                    for (int i = 0; i < L; i++) begin
                        if (i < X) dina_next[i*RSA_DW +: RSA_DW] = C_TB_dina[(X-1-i)*RSA_DW +: RSA_DW];
                    end
                    wea_next = '1;
                end
                DIR_NEW: begin
                    if (l_k_0) begin
                        dina_next[0 +: RSA_DW]      = c0;
                        dina_next[RSA_DW +: RSA_DW] = c1;
                        wea_next[1:0]               = 2'b11;
                    end else begin
                        dina_next[2*RSA_DW +: RSA_DW] = c0;
                        dina_next[3*RSA_DW +: RSA_DW] = c1;
                        wea_next[3:2]                 = 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            TB_dina  <= '0;
            TB_wea   <= '0;
            tr_state <= TR_ROW0;
            tr_busy  <= 1'b0;
            // NOTE: the transpose buffer is three flops, not a RAM, so it is
            // cleared on reset like any other state.
            r0_lo    <= '0;
            r0_hi    <= '0;
            r1_hi    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values computed above.
            TB_dina  <= dina_next;
            TB_wea   <= wea_next;
            tr_state <= tr_state_next;
            tr_busy  <= (tr_state_next != TR_ROW0);
            r0_lo    <= r0_lo_next;
            r0_hi    <= r0_hi_next;
            r1_hi    <= r1_hi_next;
        end
    end

    // TB_addra is the counter itself: it names the write on the bus now and
    // advances once that write has been presented. A load overrides the
    // advance but never the address of the write already on the bus.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            TB_addra <= '0;
        end else if (addr_load) begin
            TB_addra <= addr_base;
        end else if (|TB_wea) begin
            TB_addra <= TB_addra + ADDR_ONE;
        end
    end

endmodule

// File: tb/tb_tb_dina_map.sv
// -----------------------------------------------------------------------------
// tb_tb_dina_map
//
// Bench for tb_dina_map: single-cycle C layouts from a vector table, hand
// sequences for reset, transpose pairing, gaps, address wrap/load and mode
// changes, then random segments checked as a write stream against a row-level
// reference model.
// -----------------------------------------------------------------------------
module tb_tb_dina_map;

    localparam int X  = 4;
    localparam int L  = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = 5;
    localparam int W  = L * DW;
    localparam int NV = 9;

    localparam logic [SW-1:0] SEL_IDLE  = 5'b000_00;
    localparam logic [SW-1:0] SEL_CIDLE = 5'b001_00;
    localparam logic [SW-1:0] SEL_POS   = 5'b001_01;
    localparam logic [SW-1:0] SEL_NEG   = 5'b001_10;
    localparam logic [SW-1:0] SEL_NEW   = 5'b001_11;
    localparam logic [SW-1:0] SEL_TR    = 5'b100_00;
    localparam logic [SW-1:0] SEL_BAD   = 5'b010_01;

    logic                 clk = 1'b0;
    logic                 sys_rst_n;
    logic [SW-1:0]        sel;
    logic                 l_k_0;
    logic                 C_valid;
    logic [X*DW-1:0]      c_row;
    logic                 addr_load;
    logic [AW-1:0]        addr_base;
    logic signed [W-1:0]  TB_dina;
    logic [L-1:0]         TB_wea;
    logic [AW-1:0]        TB_addra;
    logic                 tr_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tb_dina_map #(
        .X(X), .L(L), .RSA_DW(DW), .TB_AW(AW), .TB_DINA_SEL_DW(SW)
    ) dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .TB_dina_sel(sel),
        .l_k_0      (l_k_0),
        .C_valid    (C_valid),
        .C_TB_dina  (c_row),
        .addr_load  (addr_load),
        .addr_base  (addr_base),
        .TB_dina    (TB_dina),
        .TB_wea     (TB_wea),
        .TB_addra   (TB_addra),
        .tr_busy    (tr_busy)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [L-1:0]  wea;
        logic [AW-1:0] addr;
    } wr_t;

    typedef struct {
        string         name;
        logic [SW-1:0] sel;
        logic          lk;
        logic          valid;
        logic [W-1:0]  row;
        logic [W-1:0]  data;
        logic [L-1:0]  wea;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t vecs [NV];
    wr_t  exp_q [$];
    wr_t  obs_q [$];
    logic mon_en = 1'b0;

    // Reference model state: next write address and a half-built TR pair.
    logic [AW-1:0] m_addr;
    logic          have_pend;
    logic [DW-1:0] pend_lo, pend_hi;

    function automatic logic [W-1:0] pack4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [DW-1:0] lane(input logic [W-1:0] row, input int i);
        return row[i*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [W-1:0] d, input logic [L-1:0] we,
                             input logic [AW-1:0] a);
        check({name, "_data"}, TB_dina, d);
        check({name, "_wea"}, W'(TB_wea), W'(we));
        check({name, "_addr"}, W'(TB_addra), W'(a));
    endtask

    task automatic check_idle(input string name);
        check({name, "_data"}, TB_dina, '0);
        check({name, "_wea"}, W'(TB_wea), '0);
    endtask

    task automatic check_busy(input string name, input logic b);
        check({name, "_busy"}, W'(tr_busy), W'(b));
    endtask

    task automatic drive(input logic [SW-1:0] s, input logic v, input logic [W-1:0] row,
                         input logic lk);
        sel     = s;
        C_valid = v;
        c_row   = row;
        l_k_0   = lk;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mon_en && (TB_wea != '0)) begin
            wr_t w;
            w.data = TB_dina;
            w.wea  = TB_wea;
            w.addr = TB_addra;
            obs_q.push_back(w);
        end
    endtask

    task automatic load_addr(input logic [AW-1:0] base);
        drive(SEL_IDLE, 1'b0, '0, 1'b0);
        addr_load = 1'b1;
        addr_base = base;
        step();
        addr_load = 1'b0;
    endtask

    task automatic model_push(input logic [W-1:0] d, input logic [L-1:0] we);
        wr_t w;
        w.data = d;
        w.wea  = we;
        w.addr = m_addr;
        exp_q.push_back(w);
        m_addr = AW'(int'(m_addr) + 1);
    endtask

    // Row-level model: each valid row either yields a write directly or is
    // paired with its predecessor into two transposed writes.
    task automatic model_cycle(input logic [SW-1:0] s, input logic v, input logic [W-1:0] row,
                               input logic lk);
        if (s != SEL_TR) have_pend = 1'b0;
        if (v) begin
            case (s)
                SEL_POS: model_push(row, 4'b1111);
                SEL_NEG: model_push(pack4(lane(row, 3), lane(row, 2), lane(row, 1), lane(row, 0)), 4'b1111);
                SEL_NEW: begin
                    if (lk) model_push(pack4(lane(row, 0), lane(row, 1), 0, 0), 4'b0011);
                    else    model_push(pack4(0, 0, lane(row, 0), lane(row, 1)), 4'b1100);
                end
                SEL_TR: begin
                    if (!have_pend) begin
                        pend_lo   = lane(row, 0);
                        pend_hi   = lane(row, 1);
                        have_pend = 1'b1;
                    end else begin
                        model_push(pack4(pend_lo, lane(row, 0), 0, 0), 4'b0011);
                        model_push(pack4(pend_hi, lane(row, 1), 0, 0), 4'b0011);
                        have_pend = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        vecs[0] = '{"pos",    SEL_POS,   1'b0, 1'b1, pack4(1, 2, 3, 4),     pack4(1, 2, 3, 4),   4'b1111, 10'd5};
        vecs[1] = '{"neg",    SEL_NEG,   1'b0, 1'b1, pack4(5, 6, 7, 8),     pack4(8, 7, 6, 5),   4'b1111, 10'd6};
        vecs[2] = '{"new_lo", SEL_NEW,   1'b1, 1'b1, pack4(9, 10, 11, 12),  pack4(9, 10, 0, 0),  4'b0011, 10'd7};
        vecs[3] = '{"new_hi", SEL_NEW,   1'b0, 1'b1, pack4(9, 10, 11, 12),  pack4(0, 0, 9, 10),  4'b1100, 10'd8};
        vecs[4] = '{"c_idle", SEL_CIDLE, 1'b0, 1'b1, pack4(1, 1, 1, 1),     '0,                  4'b0000, 10'd9};
        vecs[5] = '{"novalid",SEL_POS,   1'b0, 1'b0, pack4(2, 2, 2, 2),     '0,                  4'b0000, 10'd9};
        vecs[6] = '{"m_idle", SEL_IDLE,  1'b0, 1'b1, pack4(3, 3, 3, 3),     '0,                  4'b0000, 10'd9};
        vecs[7] = '{"m_bad",  SEL_BAD,   1'b0, 1'b1, pack4(4, 4, 4, 4),     '0,                  4'b0000, 10'd9};
        vecs[8] = '{"signed", SEL_POS,   1'b0, 1'b1,
                    pack4(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000),
                    pack4(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000), 4'b1111, 10'd9};

        // Reset state
        sys_rst_n = 1'b0;
        addr_load = 1'b0;
        addr_base = '0;
        drive(SEL_IDLE, 1'b0, '0, 1'b0);
        #12;
        check_out("reset", '0, '0, '0);
        check_busy("reset", 1'b0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        step();
        check_out("post_reset", '0, '0, '0);

        // Single-cycle C layouts from the table
        load_addr(10'd5);
        check_out("load5", '0, '0, 10'd5);
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].sel, vecs[i].valid, vecs[i].row, vecs[i].lk);
            step();
            check_out(vecs[i].name, vecs[i].data, vecs[i].wea, vecs[i].addr);
        end

        // Reset in the middle of a transpose pair
        drive(SEL_TR, 1'b1, pack4(1, 2, 0, 0), 1'b0);
        step();
        check_out("tr_r0", '0, '0, 10'd10);
        check_busy("tr_r0", 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        check_out("rst_mid", '0, '0, '0);
        check_busy("rst_mid", 1'b0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        drive(SEL_TR, 1'b1, pack4(3, 4, 0, 0), 1'b0);
        step();
        check_idle("rst_r0");
        check_busy("rst_r0", 1'b1);
        drive(SEL_TR, 1'b1, pack4(5, 6, 0, 0), 1'b0);
        step();
        check_out("rst_w0", pack4(3, 5, 0, 0), 4'b0011, 10'd0);
        drive(SEL_TR, 1'b0, '0, 1'b0);
        step();
        check_out("rst_w1", pack4(4, 6, 0, 0), 4'b0011, 10'd1);
        step();
        check_out("rst_done", '0, '0, 10'd2);
        check_busy("rst_done", 1'b0);

        // Back-to-back transpose pairs
        load_addr(10'd100);
        drive(SEL_TR, 1'b1, pack4(1, 2, 0, 0), 1'b0);
        step();
        check_idle("b2b_r0");
        drive(SEL_TR, 1'b1, pack4(3, 4, 0, 0), 1'b0);
        step();
        check_out("b2b_w0", pack4(1, 3, 0, 0), 4'b0011, 10'd100);
        drive(SEL_TR, 1'b1, pack4(5, 6, 0, 0), 1'b0);
        step();
        check_out("b2b_w1", pack4(2, 4, 0, 0), 4'b0011, 10'd101);
        drive(SEL_TR, 1'b1, pack4(7, 8, 0, 0), 1'b0);
        step();
        check_out("b2b_w2", pack4(5, 7, 0, 0), 4'b0011, 10'd102);
        drive(SEL_TR, 1'b0, '0, 1'b0);
        step();
        check_out("b2b_w3", pack4(6, 8, 0, 0), 4'b0011, 10'd103);
        step();
        check_out("b2b_done", '0, '0, 10'd104);
        check_busy("b2b_done", 1'b0);

        // Gaps between transpose rows
        drive(SEL_TR, 1'b1, pack4(11, 12, 0, 0), 1'b0);
        step();
        check_idle("gap_r0");
        drive(SEL_TR, 1'b0, '0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            step();
            check_idle($sformatf("gap%0d", g));
            check_busy($sformatf("gap%0d", g), 1'b1);
        end
        drive(SEL_TR, 1'b1, pack4(13, 14, 0, 0), 1'b0);
        step();
        check_out("gap_w0", pack4(11, 13, 0, 0), 4'b0011, 10'd104);
        drive(SEL_TR, 1'b0, '0, 1'b0);
        step();
        check_out("gap_w1", pack4(12, 14, 0, 0), 4'b0011, 10'd105);
        step();
        check_busy("gap_done", 1'b0);

        // Address wrap and load colliding with a write
        load_addr(10'd1023);
        drive(SEL_POS, 1'b1, pack4(1, 2, 3, 4), 1'b0);
        step();
        check_out("wrap_w0", pack4(1, 2, 3, 4), 4'b1111, 10'd1023);
        drive(SEL_POS, 1'b1, pack4(5, 6, 7, 8), 1'b0);
        step();
        check_out("wrap_w1", pack4(5, 6, 7, 8), 4'b1111, 10'd0);
        addr_load = 1'b1;
        addr_base = 10'd20;
        drive(SEL_POS, 1'b1, pack4(9, 10, 11, 12), 1'b0);
        step();
        addr_load = 1'b0;
        check_out("coll_w2", pack4(9, 10, 11, 12), 4'b1111, 10'd20);
        drive(SEL_IDLE, 1'b0, '0, 1'b0);
        step();
        check_out("coll_hold", '0, '0, 10'd21);

        // Leaving TR from TR_ROW1 drops the half pair; from TR_OUT1 finishes it
        drive(SEL_TR, 1'b1, pack4(1, 2, 0, 0), 1'b0);
        step();
        check_busy("mc_r0", 1'b1);
        drive(SEL_POS, 1'b1, pack4(3, 4, 5, 6), 1'b0);
        step();
        check_out("mc_pos", pack4(3, 4, 5, 6), 4'b1111, 10'd21);
        check_busy("mc_pos", 1'b0);
        drive(SEL_TR, 1'b1, pack4(7, 8, 0, 0), 1'b0);
        step();
        check_idle("mc_fresh_r0");
        drive(SEL_TR, 1'b1, pack4(9, 10, 0, 0), 1'b0);
        step();
        check_out("mc_w0", pack4(7, 9, 0, 0), 4'b0011, 10'd22);
        drive(SEL_IDLE, 1'b0, '0, 1'b0);
        step();
        check_out("mc_w1", pack4(8, 10, 0, 0), 4'b0011, 10'd23);
        check_busy("mc_w1", 1'b0);
        step();
        check_out("mc_done", '0, '0, 10'd24);

        // Random segments against the row-level model
        begin
            logic [AW-1:0] base;
            base = AW'($urandom_range(0, 1023));
            load_addr(base);
            m_addr    = base;
            have_pend = 1'b0;
            mon_en    = 1'b1;
            for (int seg = 0; seg < 40; seg++) begin
                logic [SW-1:0] s;
                int            len;
                case ($urandom_range(0, 5))
                    0:       s = SEL_POS;
                    1:       s = SEL_NEG;
                    2:       s = SEL_NEW;
                    3:       s = SEL_CIDLE;
                    default: s = SEL_TR;
                endcase
                len = $urandom_range(3, 10);
                for (int c = 0; c < len; c++) begin
                    logic          v;
                    logic          lk;
                    logic [W-1:0]  row;
                    v   = ($urandom_range(0, 3) != 0);
                    lk  = 1'($urandom_range(0, 1));
                    row = {$urandom(), $urandom(), $urandom(), $urandom()};
                    drive(s, v, row, lk);
                    model_cycle(s, v, row, lk);
                    step();
                end
                drive(SEL_IDLE, 1'b0, '0, 1'b0);
                for (int c = 0; c < 2; c++) begin
                    model_cycle(SEL_IDLE, 1'b0, '0, 1'b0);
                    step();
                end
            end
            mon_en = 1'b0;
            check("rand_count", W'(obs_q.size()), W'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                check($sformatf("rand%0d_data", i), obs_q[i].data, exp_q[i].data);
                check($sformatf("rand%0d_wea", i), W'(obs_q[i].wea), W'(exp_q[i].wea));
                check($sformatf("rand%0d_addr", i), W'(obs_q[i].addr), W'(exp_q[i].addr));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tb_dina_map.md
Name: tb_dina_map

Overview:
- Write-side counterpart of the tile-buffer read mapper: takes result rows from the RSA output edge (C lanes) and maps them onto the tile-buffer port-A write bus.
- Produces the data word, per-lane write enables and write address.
- Supports direct, lane-reversed, half-word (2-lane) and 2x2-transpose writeback, so results land in TB in the same layout the read mapper expects.

Parameters:
X, 4, RSA output lane count (C width in elements)
L, 4, tile-buffer lanes per word
RSA_DW, 32, element width in bits
TB_AW, 10, tile-buffer address width
TB_DINA_SEL_DW, 5, width of mode select

Ports:
clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
TB_dina_sel  in  TB_DINA_SEL_DW  [4:2] mode: 000 IDLE, 001 C, 100 TR (transpose); [1:0] dir for C: 00 IDLE, 01 POS, 10 NEG, 11 NEW
l_k_0  in  1  NEW half select: 1 = lanes 0-1, 0 = lanes 2-3
C_valid  in  1  C_TB_dina holds a valid row this cycle
C_TB_dina  in  X*RSA_DW  signed result row from RSA
addr_load  in  1  load write address counter
addr_base  in  TB_AW  start address
TB_dina  out  L*RSA_DW  signed write data, registered
TB_wea  out  L  per-lane write enable, registered
TB_addra  out  TB_AW  write address, registered
tr_busy  out  1  transpose holds a first row awaiting its pair

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. On reset: TB_dina=0, TB_wea=0, TB_addra=0, tr_busy=0, transpose buffer cleared, TR state = TR_ROW0.
- Latency: 1 cycle from C_valid to TB_wea/TB_dina in every mode except TR.
- When no write occurs in a cycle: TB_wea=0 and TB_dina=0.

Mode C, driven only when C_valid=1:
- POS: TB_dina = C_TB_dina. wea = 1111.
- NEG: lane i = C lane (X-1-i). wea = 1111.
- NEW, l_k_0=1: lanes 0,1 = C lanes 0,1; lanes 2,3 = 0; wea = 0011.
- NEW, l_k_0=0: lanes 2,3 = C lanes 0,1; lanes 0,1 = 0; wea = 1100.
- dir IDLE: wea = 0.

Mode TR, 2x2 transpose using C lanes 0-1 only. FSM states:
- TR_ROW0: on C_valid, store r0 = {C0, C1}. Set tr_busy=1. Go to TR_ROW1. No write this cycle.
- TR_ROW1: on C_valid, store r1. Next cycle write {r0[0], r1[0], 0, 0} with wea=0011. Go to TR_OUT1.
- TR_OUT1: write {r0[1], r1[1], 0, 0} with wea=0011. tr_busy=0. Go to TR_ROW0.
  - If C_valid=1 in this cycle, it is captured as the new r0 and the FSM goes to TR_ROW1 instead (back-to-back pairs, no stall).

Mode change:
- Leaving TR (select != 100) in any state returns the FSM to TR_ROW0 and clears tr_busy.
- A pending TR_OUT1 write is still issued on that cycle.

Address counter:
- TB_addra is the address of the write presented on the same cycle as TB_wea.
- After every cycle with TB_wea != 0, the counter increments by 1 and wraps modulo 2^TB_AW (all-ones -> 0).
- addr_load=1 sets the next counter value to addr_base.
- addr_load and a write in the same cycle: the write uses the current address; load wins for the next value.
- C_valid=0 or mode IDLE: counter holds.

Arithmetic:
- Pure routing, no arithmetic.
- Unused output lanes are driven to 0.

Test Plan:
- Reset: hold sys_rst_n=0 mid-TR (after r0 captured), release -> TB_wea=0, tr_busy=0, TB_addra=0; next TR row is treated as r0.
- POS/NEG: addr_load with base 5; C rows {1,2,3,4}, {5,6,7,8}, valid on both cycles (POS then NEG) -> writes {1,2,3,4}@5 wea 1111, then {8,7,6,5}@6.
- NEW: C {9,10,11,12}: with l_k_0=1 -> lanes {9,10,0,0}, wea 0011; with l_k_0=0 -> lanes {0,0,9,10}, wea 1100; address increments each write.
- TR back-to-back: rows {1,2}, {3,4}, {5,6}, {7,8}, valid on consecutive cycles -> writes {1,3}, {2,4}, {5,7}, {6,8}, all wea 0011, consecutive addresses, no dropped row.
- Wrap/collision: base = 2^TB_AW-1, two POS writes -> addresses all-ones then 0. addr_load=1 with base 20 during the second write -> that write at 0, next write at 20.
- Gaps: C_valid=0 between TR rows -> FSM waits in TR_ROW1, tr_busy=1, no writes; the pair completes when the second row arrives.
